// File: rtl/count_pkg.sv
// Shared types and helpers for the loadable 4-bit counter stage and its checkers.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } cm_state_t;

  localparam int unsigned CNT_W = 4;

  // Successor of a counter value with natural wrap (15 -> 0).
  function automatic logic [CNT_W-1:0] seq_next(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/period_out_reg.sv
// Single-entry valid/ready holding register; a result arriving while full is dropped and flagged.
module period_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         emit_i,
  input  logic [W-1:0] emit_data_i,
  input  logic         clr_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overrun_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         overrun_q, overrun_d;

  // A new overrun in the same cycle as a clear keeps the flag set.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q & ~clr_i;
    if (emit_i) begin
      if (!valid_q || ready_i) begin
        data_d  = emit_data_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Checks the counter's number/zero stream for +1 sequencing and flag consistency,
// and measures the zero-to-zero period delivered through a valid/ready register.
module count_seq_monitor
  import count_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] number,
  input  logic             zero,
  input  logic             resync,
  input  logic             clr_err,
  output logic [PW-1:0]    period_data,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             seq_err,
  output logic             zero_err,
  output logic             overrun,
  output logic             locked
);

  localparam logic [PW-1:0] CNT_MAX = '1;

  cm_state_t        state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             seq_err_q, seq_err_d;
  logic             zero_err_q, zero_err_d;
  logic             locked_q, locked_d;
  logic             seq_bad, seq_hit, zero_hit, emit;
  logic [PW-1:0]    cnt_inc;

  assign seq_bad  = (number != seq_next(prev_q));
  assign zero_hit = (zero != (number == '0));
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PW'(1);

  // Resync outranks everything; in SYNC a zero sample relocks even if it also broke sequence.
  always_comb begin
    state_d = state_q;
    prev_d  = number;
    cnt_d   = cnt_q;
    seq_hit = 1'b0;
    emit    = 1'b0;
    if (resync) begin
      state_d = SYNC;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (zero) begin
            cnt_d   = '0;
            state_d = TRACK;
          end else begin
            state_d = SYNC;
          end
        end
        SYNC: begin
          seq_hit = seq_bad;
          if (zero) begin
            cnt_d   = '0;
            state_d = TRACK;
          end
        end
        TRACK: begin
          seq_hit = seq_bad;
          if (seq_bad) begin
            state_d = SYNC;
            cnt_d   = '0;
          end else if (zero) begin
            emit  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    seq_err_d  = seq_hit | (seq_err_q & ~clr_err);
    zero_err_d = zero_hit | (zero_err_q & ~clr_err);
    locked_d   = (state_d == TRACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      cnt_q      <= '0;
      seq_err_q  <= 1'b0;
      zero_err_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      seq_err_q  <= seq_err_d;
      zero_err_q <= zero_err_d;
      locked_q   <= locked_d;
    end
  end

  period_out_reg #(.W(PW)) u_out (
    .clk        (clk),
    .rst        (rst),
    .emit_i     (emit),
    .emit_data_i(cnt_inc),
    .clr_i      (clr_err),
    .ready_i    (period_ready),
    .data_o     (period_data),
    .valid_o    (period_valid),
    .overrun_o  (overrun)
  );

  assign seq_err  = seq_err_q;
  assign zero_err = zero_err_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Scoreboard bench: one monitor at PW=8 and one at PW=4 share the same counter stream.
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       rst, zero, resync, clr_err, period_ready;
  logic [3:0] number;

  logic [7:0] pd8;
  logic [3:0] pd4;
  logic       pv8, se8, ze8, ov8, lk8;
  logic       pv4, se4, ze4, ov4, lk4;

  always #5 clk = ~clk;

  count_seq_monitor #(.PW(8)) dut8 (
    .clk(clk), .rst(rst), .number(number), .zero(zero), .resync(resync),
    .clr_err(clr_err), .period_data(pd8), .period_valid(pv8),
    .period_ready(period_ready), .seq_err(se8), .zero_err(ze8),
    .overrun(ov8), .locked(lk8)
  );

  count_seq_monitor #(.PW(4)) dut4 (
    .clk(clk), .rst(rst), .number(number), .zero(zero), .resync(resync),
    .clr_err(clr_err), .period_data(pd4), .period_valid(pv4),
    .period_ready(period_ready), .seq_err(se4), .zero_err(ze4),
    .overrun(ov4), .locked(lk4)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: expected state after the next rising edge.
  bit m_started, m_locked, m_valid, m_seq, m_zer, m_ovr;
  int m_prev, m_run;
  int q8[$];
  int q4[$];

  int cv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input int n, input bit z, input bit rs,
                            input bit ce, input bit rdy);
    bit emit, shit, zhit, ohit, brk;
    int val;
    emit = 1'b0; shit = 1'b0; ohit = 1'b0; val = 0;
    if (r) begin
      m_started = 1'b0; m_locked = 1'b0; m_valid = 1'b0;
      m_seq = 1'b0; m_zer = 1'b0; m_ovr = 1'b0;
      m_prev = 0; m_run = 0;
      q8.delete(); q4.delete();
      return;
    end
    zhit = (z != (n == 0));
    if (rs) begin
      m_started = 1'b1; m_locked = 1'b0; m_run = 0;
    end else if (!m_started) begin
      m_started = 1'b1;
      if (z) begin m_locked = 1'b1; m_run = 0; end
    end else begin
      brk  = (n != (m_prev + 1) % 16);
      shit = brk;
      if (m_locked) begin
        if (brk) m_locked = 1'b0;
        else if (z) begin emit = 1'b1; val = m_run + 1; m_run = 0; end
        else m_run++;
      end else if (z) begin
        m_locked = 1'b1; m_run = 0;
      end
    end
    m_prev = n;
    if (emit) begin
      if (!m_valid || rdy) begin
        q8.push_back(val > 255 ? 255 : val);
        q4.push_back(val > 15 ? 15 : val);
        m_valid = 1'b1;
      end else begin
        ohit = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_seq = shit || (m_seq && !ce);
    m_zer = zhit || (m_zer && !ce);
    m_ovr = ohit || (m_ovr && !ce);
  endtask

  task automatic drive(input bit r, input int n, input bit z, input bit rs,
                       input bit ce, input bit rdy);
    @(negedge clk);
    rst = r; number = 4'(n); zero = z; resync = rs; clr_err = ce; period_ready = rdy;
    model_step(r, n, z, rs, ce, rdy);
  endtask

  task automatic free(input int cycles, input bit rdy);
    for (int i = 0; i < cycles; i++) begin
      drive(1'b0, cv, cv == 0, 1'b0, 1'b0, rdy);
      cv = (cv + 1) % 16;
    end
  endtask

  // Monitor: flags compared every cycle, periods popped whenever a new value is presented.
  initial begin
    bit last8, last4;
    last8 = 1'b0; last4 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      check("valid8", 32'(pv8), 32'(m_valid));
      check("valid4", 32'(pv4), 32'(m_valid));
      check("seq_err8", 32'(se8), 32'(m_seq));
      check("seq_err4", 32'(se4), 32'(m_seq));
      check("zero_err8", 32'(ze8), 32'(m_zer));
      check("zero_err4", 32'(ze4), 32'(m_zer));
      check("overrun8", 32'(ov8), 32'(m_ovr));
      check("overrun4", 32'(ov4), 32'(m_ovr));
      check("locked8", 32'(lk8), 32'(m_locked));
      check("locked4", 32'(lk4), 32'(m_locked));
      if (pv8 === 1'b1 && (!last8 || period_ready === 1'b1)) begin
        if (q8.size() == 0) check("period8_unexpected", 32'(pd8), 32'hFFFF_FFFF);
        else check("period8", 32'(pd8), 32'(q8.pop_front()));
      end
      if (pv4 === 1'b1 && (!last4 || period_ready === 1'b1)) begin
        if (q4.size() == 0) check("period4_unexpected", 32'(pd4), 32'hFFFF_FFFF);
        else check("period4", 32'(pd4), 32'(q4.pop_front()));
      end
      last8 = (pv8 === 1'b1);
      last4 = (pv4 === 1'b1);
    end
  end

  initial begin
    int r;
    bit rs, z, ce, rdy, rv;
    rst = 1'b1; number = '0; zero = 1'b1; resync = 1'b0; clr_err = 1'b0; period_ready = 1'b1;
    model_step(1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    cv = 0;

    free(40, 1'b1);                                  // clean free-run
    while (cv != 9) free(1, 1'b1);
    cv = 10; drive(1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b1);  // load 10 with resync
    cv = 11; free(40, 1'b1);
    while (cv != 6) free(1, 1'b1);
    cv = 9; free(40, 1'b1);                          // jump 5 -> 9
    drive(1'b0, cv, cv == 0, 1'b0, 1'b1, 1'b1); cv = (cv + 1) % 16;
    while (cv != 3) free(1, 1'b1);
    drive(1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b1); cv = 4;  // zero flag wrong at 3
    free(35, 1'b1);
    free(40, 1'b0);                                  // stalled consumer
    free(20, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1);          // mid-run reset
    cv = 0; free(20, 1'b1);
    for (int i = 0; i < 300; i++) begin              // zero suppressed: long periods saturate
      drive(1'b0, cv, 1'b0, 1'b0, 1'b0, 1'b1);
      cv = (cv + 1) % 16;
    end
    free(40, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      r  = int'($urandom_range(0, 99));
      rs = (r < 3);
      if (r < 6) cv = int'($urandom_range(0, 15));
      z = (cv == 0);
      if ($urandom_range(0, 99) < 3) z = !z;
      ce  = ($urandom_range(0, 99) < 5);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 999) < 3);
      drive(rv, cv, z, rs, ce, rdy);
      cv = (cv + 1) % 16;
    end
    free(20, 1'b1);
    @(posedge clk); #2;
    check("q8_left", 32'(q8.size()), 32'd0);
    check("q4_left", 32'(q4.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
